fft_input_sequencer: RTL and testbench
======================================

FFT_INPUT_SEQUENCER -- requirements
Module: fft_input_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one input sample word.
REQ-002 Parameter N_SEG, default 8, number of downstream 8-deep input segments.
REQ-003 Parameter SEG_DEPTH, default 8, samples per segment; frame length is N_SEG*SEG_DEPTH, i.e. 64 by default.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  single-cycle request to begin loading a frame.
REQ-007 in_valid  input  1  source presents a sample on in_data.
REQ-008 in_data  input  DATA_WIDTH  input sample.
REQ-009 in_ready  output  1  sequencer accepts a sample this cycle.
REQ-010 seg_data  output  DATA_WIDTH  shared D bus to all segments.
REQ-011 seg_hold  output  N_SEG  per-segment hold; bit s low means segment s shifts this cycle.
REQ-012 seg_index  output  log2(N_SEG)  segment currently being filled.
REQ-013 frame_valid  output  1  a complete frame sits in the segments.
REQ-014 frame_ack  input  1  FFT core has consumed the frame.
REQ-015 overflow  output  1  sticky flag: a sample was offered while the sequencer was not ready.

Function
REQ-016 The sequencer SHALL implement three states: IDLE, LOAD and FULL.
REQ-017 In IDLE, start=1 SHALL move the state to LOAD on the next edge; all other inputs are ignored in IDLE.
REQ-018 in_ready SHALL be combinational and equal to (state==LOAD).
REQ-019 An accept SHALL be defined as in_valid & in_ready.
REQ-020 A 6-bit sample counter (log2 of frame length) SHALL increment by 1 on each accept.
- It is 0 on entry to LOAD.
REQ-021 On an accept of sample k, the next cycle SHALL present seg_data=in_data with seg_hold bit (k/SEG_DEPTH) low and all other seg_hold bits high.
- Latency is exactly 1 cycle.
REQ-022 In any cycle after a non-accept, seg_hold SHALL be all ones and seg_data SHALL retain its last value.
REQ-023 seg_index SHALL equal counter/SEG_DEPTH and be registered alongside seg_data.
- seg_index reads 0..N_SEG-1 during a frame.
REQ-024 The accept of sample N_SEG*SEG_DEPTH-1 (the 64th sample) SHALL cause the following:
- move to FULL;
- wrap the counter to 0;
- the cycle after that last write, assert frame_valid, so it rises together with the last segment write.
REQ-025 In FULL, frame_valid SHALL stay 1 and in_ready SHALL stay 0 until frame_ack=1.
- frame_ack then clears frame_valid and moves the state to LOAD on the next edge, so back-to-back frames need no new start.
REQ-026 frame_ack outside FULL SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-027 in_valid=1 while in_ready=0 in LOAD or FULL SHALL set overflow on the next edge.
- overflow stays set until rst.
- in_valid in IDLE does not set overflow.
REQ-028 in_valid=1 and frame_ack=1 in the same FULL cycle SHALL set overflow and SHALL NOT accept the sample.
REQ-029 All outputs except in_ready SHALL be registered.

Reset
REQ-030 On rst=1 at an edge, the block SHALL return to this state:
- state=IDLE, counter=0;
- seg_data=0, seg_hold=all ones, seg_index=0;
- frame_valid=0, overflow=0.
- in_ready is therefore 0.
REQ-031 rst SHALL take priority over start, in_valid and frame_ack in the same cycle.
REQ-032 rst asserted mid-LOAD SHALL discard the partial frame, with no further seg_hold low pulses after the reset edge.

Verification
REQ-033 Reset, then start, then 64 consecutive accepts of values 1..64 SHALL produce the following:
- seg_hold[0] low for samples 1..8, seg_hold[7] low for samples 57..64;
- seg_index stepping 0..7;
- frame_valid=1 one cycle after the 64th accept.
REQ-034 in_valid toggled 1,0,1,0 during LOAD SHALL make seg_hold low only in the cycles following each accept, with seg_data holding between them.
REQ-035 A full frame held for 5 cycles with in_valid=1 and then frame_ack SHALL produce the following:
- in_ready=0 for those 5 cycles and overflow=1;
- frame_valid=0 and state=LOAD one cycle after ack;
- the next sample going into segment 0.
REQ-036 rst after 20 accepts SHALL produce the following:
- seg_hold=all ones and in_ready=0 next cycle;
- after start, the first sample lands in segment 0 with seg_index=0.
REQ-037 frame_ack during LOAD, and start during FULL, SHALL leave state, counter and frame_valid unchanged.
REQ-038 in_valid=1 in IDLE for 3 cycles SHALL produce no seg_hold low pulse and SHALL leave overflow=0.

Source files
------------

// File: rtl/fft_input_sequencer_if.sv
// rtl/fft_input_sequencer_if.sv - sample source, segment bus and frame handshake bundle for the FFT input sequencer
interface fft_input_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_SEG      = 8
);
  localparam int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] seg_data;
  logic [N_SEG-1:0]      seg_hold;
  logic [IDX_W-1:0]      seg_index;
  logic                  frame_valid;
  logic                  frame_ack;
  logic                  overflow;

  // Controller / sample-source side
  modport master (
    output start, in_valid, in_data, frame_ack,
    input  in_ready, seg_data, seg_hold, seg_index, frame_valid, overflow
  );

  // Sequencer side
  modport slave (
    input  start, in_valid, in_data, frame_ack,
    output in_ready, seg_data, seg_hold, seg_index, frame_valid, overflow
  );
endinterface

// File: rtl/fft_input_sequencer.sv
// rtl/fft_input_sequencer.sv - loads one frame of samples into N_SEG shift segments for an FFT core
// Segments shift on a low seg_hold bit; one shared data bus feeds all of them.
module fft_input_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int N_SEG      = 8,
  parameter int SEG_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  fft_input_sequencer_if.slave bus
);
  localparam int FRAME_LEN = N_SEG * SEG_DEPTH;
  localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int IDX_W     = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  in_ready_c;
  logic                  accept;
  logic                  last_accept;
  logic                  ack_full;
  logic                  overflow_set;
  logic [IDX_W-1:0]      seg_sel;
  logic [N_SEG-1:0]      write_mask;

  logic [DATA_WIDTH-1:0] seg_data_q;
  logic [N_SEG-1:0]      seg_hold_q;
  logic [IDX_W-1:0]      seg_index_q;
  logic                  frame_valid_q;
  logic                  overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    ack_full    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready_c  = 1'b1;
        accept      = bus.in_valid;
        last_accept = bus.in_valid && (cnt == LAST);
        if (last_accept) begin
          state_next = FULL;
        end
      end
      FULL: begin
        // Ack re-arms loading directly so consecutive frames need no start
        ack_full = bus.frame_ack;
        if (bus.frame_ack) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counter is forced to zero while idle so every LOAD entry starts at sample 0
  always_comb begin
    cnt_next = cnt;
    if (state == IDLE) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = last_accept ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    seg_sel = IDX_W'(int'(cnt) / SEG_DEPTH);
    for (int s = 0; s < N_SEG; s++) begin
      write_mask[s] = (IDX_W'(s) != seg_sel);
    end
  end

  // Only a live load or a held frame can lose samples; idle traffic is ignored
  assign overflow_set = bus.in_valid && !in_ready_c && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      seg_data_q    <= '0;
      seg_hold_q    <= '1;
      seg_index_q   <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      seg_hold_q <= accept ? write_mask : '1;
      if (accept) begin
        seg_data_q  <= bus.in_data;
        seg_index_q <= seg_sel;
      end
      if (last_accept) begin
        frame_valid_q <= 1'b1;
      end else if (ack_full) begin
        frame_valid_q <= 1'b0;
      end
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.seg_data    = seg_data_q;
  assign bus.seg_hold    = seg_hold_q;
  assign bus.seg_index   = seg_index_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_fft_input_sequencer.sv
// tb/tb_fft_input_sequencer.sv - directed vector and sequence bench for fft_input_sequencer
module tb_fft_input_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fft_input_sequencer_if #(.DATA_WIDTH(32), .N_SEG(8)) bus ();

  fft_input_sequencer #(
    .DATA_WIDTH(32),
    .N_SEG     (8),
    .SEG_DEPTH (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        frame_ack;
    logic [31:0] in_data;
    logic        exp_ready;
    logic [7:0]  exp_hold;
    logic [31:0] exp_data;
    logic [2:0]  exp_idx;
    logic        exp_fv;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic r, logic s, logic v, logic a, logic [31:0] d,
                              logic er, logic [7:0] eh, logic [31:0] ed,
                              logic [2:0] ei, logic ef, logic eo);
    vec_t t;
    t.rst = r; t.start = s; t.in_valid = v; t.frame_ack = a; t.in_data = d;
    t.exp_ready = er; t.exp_hold = eh; t.exp_data = ed; t.exp_idx = ei;
    t.exp_fv = ef; t.exp_ovf = eo;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the edge
  task automatic drive(input logic r, input logic s, input logic v,
                       input logic [31:0] d, input logic a);
    rst           = r;
    bus.start     = s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.frame_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic er, input logic [7:0] eh,
                           input logic [31:0] ed, input logic [2:0] ei,
                           input logic ef, input logic eo);
    check({tag, " in_ready"},    {31'd0, bus.in_ready},    {31'd0, er});
    check({tag, " seg_hold"},    {24'd0, bus.seg_hold},    {24'd0, eh});
    check({tag, " seg_data"},    bus.seg_data,             ed);
    check({tag, " seg_index"},   {29'd0, bus.seg_index},   {29'd0, ei});
    check({tag, " frame_valid"}, {31'd0, bus.frame_valid}, {31'd0, ef});
    check({tag, " overflow"},    {31'd0, bus.overflow},    {31'd0, eo});
  endtask

  initial begin
    logic [7:0] hold_exp;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.frame_ack = 1'b0;
    #2;

    //             rst s  v  a  data        rdy hold   data      idx fv ovf
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,      0, 8'hFF, 32'h0,  0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 32'hAA,     0, 8'hFF, 32'h0,  0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 32'hAB,     0, 8'hFF, 32'h0,  0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 32'hAC,     0, 8'hFF, 32'h0,  0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 32'h0,      1, 8'hFF, 32'h0,  0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 32'h11,     1, 8'hFE, 32'h11, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h99,     1, 8'hFF, 32'h11, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 32'h22,     1, 8'hFE, 32'h22, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h98,     1, 8'hFF, 32'h22, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 32'h0,      1, 8'hFF, 32'h22, 0, 0, 0);
    vecs[10] = mk(0, 1, 1, 0, 32'h33,     1, 8'hFE, 32'h33, 0, 0, 0);
    vecs[11] = mk(1, 0, 1, 0, 32'h44,     0, 8'hFF, 32'h0,  0, 0, 0);
    vecs[12] = mk(1, 1, 1, 1, 32'h45,     0, 8'hFF, 32'h0,  0, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 32'h46,     0, 8'hFF, 32'h0,  0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].in_valid, vecs[i].in_data, vecs[i].frame_ack);
      check_all($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_hold,
                vecs[i].exp_data, vecs[i].exp_idx, vecs[i].exp_fv, vecs[i].exp_ovf);
    end

    // Full frame of 1..64, with a stray ack at sample 30 and a stray start at 40
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      drive(0, k == 40, 1, k, k == 30);
      hold_exp = ~(8'd1 << ((k - 1) / 8));
      check_all($sformatf("frame k%0d", k), k != 64, hold_exp, k,
                3'((k - 1) / 8), k == 64, 0);
    end

    // Frame held: samples offered are refused and flag overflow
    for (int i = 0; i < 5; i++) begin
      drive(0, i == 2, 1, 32'hDEAD0000 + i, 0);
      check_all($sformatf("full%0d", i), 0, 8'hFF, 64, 7, 1, 1);
    end
    drive(0, 0, 1, 32'hBEEF, 1);
    check_all("ack", 1, 8'hFF, 64, 7, 0, 1);
    drive(0, 0, 1, 100, 0);
    check_all("next frame s0", 1, 8'hFE, 100, 0, 0, 1);

    // Reset after 20 accepts drops the partial frame
    drive(1, 0, 0, 0, 0);
    check_all("rst clr", 0, 8'hFF, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 1, 200 + k, 0);
    end
    check_all("acc20", 1, 8'hFB, 220, 2, 0, 0);
    drive(1, 0, 1, 300, 0);
    check_all("mid rst", 0, 8'hFF, 0, 0, 0, 0);
    drive(0, 0, 1, 301, 0);
    check_all("post rst idle", 0, 8'hFF, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 77, 0);
    check_all("restart s0", 1, 8'hFE, 77, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check_all("restart hold", 1, 8'hFF, 77, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
